// File: rtl/ddr_read_scheduler_if.sv
// Bus bundle between the DDR read scheduler, its requesters and the DDR read port.
// master = scheduler side, slave = requesters plus DDR controller side.
interface ddr_read_scheduler_if #(
    parameter int N_REQ       = 4,
    parameter int WIDTH_VADDR = 24,
    parameter int WIDTH_PADDR = 28,
    parameter int BURST_LEN   = 224
);
    localparam int WIDTH_LEN = $clog2(BURST_LEN + 1);

    logic [N_REQ-1:0]             req_vld;
    logic [N_REQ*WIDTH_VADDR-1:0] req_vaddr;
    logic [N_REQ-1:0]             req_granted;
    logic [17:0]                  rd_data;
    logic [N_REQ-1:0]             rd_data_vld;
    logic                         ddr_cmd_vld;
    logic                         ddr_cmd_rdy;
    logic [WIDTH_PADDR-1:0]       ddr_cmd_addr;
    logic [WIDTH_LEN-1:0]         ddr_cmd_len;
    logic [17:0]                  ddr_rd_data;
    logic                         ddr_rd_data_vld;
    logic                         busy;
    logic                         timeout_err;

    modport master (
        input  req_vld, req_vaddr, ddr_cmd_rdy, ddr_rd_data, ddr_rd_data_vld,
        output req_granted, rd_data, rd_data_vld, ddr_cmd_vld, ddr_cmd_addr,
               ddr_cmd_len, busy, timeout_err
    );

    modport slave (
        output req_vld, req_vaddr, ddr_cmd_rdy, ddr_rd_data, ddr_rd_data_vld,
        input  req_granted, rd_data, rd_data_vld, ddr_cmd_vld, ddr_cmd_addr,
               ddr_cmd_len, busy, timeout_err
    );
endinterface

// File: rtl/ddr_read_scheduler.sv
// Round-robin scheduler sharing one DDR read port among N_REQ requesters.
// Define DDR_SCHED_TIMEOUT_EN to build the DATA-phase stall watchdog.
module ddr_read_scheduler #(
    parameter int                           N_REQ       = 4,
    parameter int                           WIDTH_VADDR = 24,
    parameter int                           WIDTH_PADDR = 28,
    parameter int                           BURST_LEN   = 224,
    parameter logic [N_REQ*WIDTH_PADDR-1:0] BASE_ADDRS  = '0,
    parameter int                           TIMEOUT_CYC = 1024
) (
    input logic                  clk,
    input logic                  reset,
    ddr_read_scheduler_if.master bus
);
    localparam int OWNER_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int WIDTH_LEN = $clog2(BURST_LEN + 1);
    localparam logic [OWNER_W-1:0] LAST_INIT = OWNER_W'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t               state;
    logic [OWNER_W-1:0]   owner;
    logic [OWNER_W-1:0]   last_owner;
    logic [BEAT_W-1:0]    beat_cnt;
    logic [OWNER_W-1:0]   next_owner;
    logic [OWNER_W-1:0]   cand;
    logic                 found;
    logic [WIDTH_PADDR-1:0] next_addr;

    assign bus.ddr_cmd_len = WIDTH_LEN'(BURST_LEN);

    // NOTE: every variable gets a default before the search loop so no latch is inferred.
    always_comb begin
        next_owner = last_owner;
        cand       = '0;
        found      = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = OWNER_W'((int'(last_owner) + i) % N_REQ);
            if (!found && bus.req_vld[cand]) begin
                found      = 1'b1;
                next_owner = cand;
            end
        end
        next_addr = BASE_ADDRS[int'(next_owner)*WIDTH_PADDR +: WIDTH_PADDR]
                  + WIDTH_PADDR'(bus.req_vaddr[int'(next_owner)*WIDTH_VADDR +: WIDTH_VADDR]);
    end

`ifdef DDR_SCHED_TIMEOUT_EN
    localparam int STALL_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [STALL_W-1:0] stall_cnt;
`else
    assign bus.timeout_err = 1'b0;
`endif

    // NOTE: state and registered outputs use non-blocking assignments so all update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            owner            <= '0;
            last_owner       <= LAST_INIT;
            beat_cnt         <= '0;
            bus.req_granted  <= '0;
            bus.rd_data      <= '0;
            bus.rd_data_vld  <= '0;
            bus.ddr_cmd_vld  <= 1'b0;
            bus.ddr_cmd_addr <= '0;
            bus.busy         <= 1'b0;
`ifdef DDR_SCHED_TIMEOUT_EN
            stall_cnt        <= '0;
            bus.timeout_err  <= 1'b0;
`endif
        end else begin
            bus.req_granted <= '0;
            bus.rd_data_vld <= '0;
`ifdef DDR_SCHED_TIMEOUT_EN
            bus.timeout_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (found) begin
                        owner            <= next_owner;
                        bus.req_granted  <= N_REQ'(1) << next_owner;
                        bus.ddr_cmd_addr <= next_addr;
                        bus.ddr_cmd_vld  <= 1'b1;
                        bus.busy         <= 1'b1;
                        state            <= CMD;
                    end
                end
                CMD: begin
`ifdef DDR_SCHED_TIMEOUT_EN
                    stall_cnt <= '0;
`endif
                    if (bus.ddr_cmd_rdy) begin
                        bus.ddr_cmd_vld <= 1'b0;
                        state           <= DATA;
                    end
                end
                DATA: begin
                    if (bus.ddr_rd_data_vld) begin
                        bus.rd_data     <= bus.ddr_rd_data;
                        bus.rd_data_vld <= N_REQ'(1) << owner;
`ifdef DDR_SCHED_TIMEOUT_EN
                        stall_cnt       <= '0;
`endif
                        if (beat_cnt == BEAT_W'(BURST_LEN - 1)) begin
                            beat_cnt   <= '0;
                            last_owner <= owner;
                            bus.busy   <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
`ifdef DDR_SCHED_TIMEOUT_EN
                    // Consecutive silent DATA cycles; the TIMEOUT_CYC-th one aborts the burst.
                    else if (stall_cnt == STALL_W'(TIMEOUT_CYC - 1)) begin
                        stall_cnt       <= '0;
                        beat_cnt        <= '0;
                        last_owner      <= owner;
                        bus.busy        <= 1'b0;
                        bus.timeout_err <= 1'b1;
                        state           <= IDLE;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
